// File: rtl/psum_requant.sv
`default_nettype none
// ============================================================================
//  Module   : psum_requant
//  Purpose  : Accumulates cfg_num_tiles adder-tree sums into one output-pixel
//             partial sum, adds a per-channel bias, requantizes the result
//             (multiply, rounding right-shift, saturate) to a signed OUT_W
//             activation and offers it through a 2-entry output buffer.
//  Ports    : clk, rst (async, active high)
//             sum_in/sum_valid            tree sums, no backpressure
//             cfg_num_tiles/bias/mult/shift  per-output config (shadowed)
//             q_out/q_valid/q_ready       valid/ready result stream
//             busy, overflow (sticky drop indicator)
//  Config   : PSUM_RELU_EN - when defined, the saturation lower bound is 0
//  Revision : 1.0 - initial release
// ============================================================================
module psum_requant #(
  parameter int ACC_W  = 48,
  parameter int MUL_W  = 16,
  parameter int OUT_W  = 8,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  sum_in,
  input  logic              sum_valid,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [ACC_W-1:0]  cfg_bias,
  input  logic [MUL_W-1:0]  cfg_mult,
  input  logic [5:0]        cfg_shift,
  output logic [OUT_W-1:0]  q_out,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int P_W = ACC_W + MUL_W + 1;  // product width
  localparam int R_W = P_W + 1;            // headroom for the rounding add

  localparam logic signed [R_W-1:0] C_HI = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
`ifdef PSUM_RELU_EN
  localparam logic signed [R_W-1:0] C_LO = '0;
`else
  localparam logic signed [R_W-1:0] C_LO = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  // Accumulate stage state and config shadows
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TILE_W-1:0] n_q, n_d;
  logic [ACC_W-1:0]  bias_q, bias_d;
  logic [MUL_W-1:0]  mult_q, mult_d;
  logic [5:0]        shift_q, shift_d;
  logic [ACC_W-1:0]  s1_q, s1_d;
  logic              s1_v_q, s1_v_d;
  logic [MUL_W-1:0]  s1_mult_q, s1_mult_d;
  logic [5:0]        s1_shift_q, s1_shift_d;
  // Multiply and round stages
  logic [P_W-1:0]    s2_q;
  logic              s2_v_q;
  logic [5:0]        s2_shift_q;
  logic [OUT_W-1:0]  s3_q;
  logic              s3_v_q;
  // Output buffer
  logic [OUT_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // On the first beat of an output the live config applies (the shadows are
  // only being loaded), so an N=1 output never sees stale shadows.
  logic              w_first, w_last;
  logic [TILE_W-1:0] w_n, w_last_idx;
  logic [ACC_W-1:0]  w_bias, w_acc_base, w_acc_sum;
  logic [MUL_W-1:0]  w_mult;
  logic [5:0]        w_shift;

  assign w_first    = (tile_cnt_q == '0);
  assign w_n        = w_first ? cfg_num_tiles : n_q;
  assign w_last_idx = (w_n == '0) ? '0 : w_n - TILE_W'(1);
  assign w_last     = (tile_cnt_q == w_last_idx);
  assign w_bias     = w_first ? cfg_bias  : bias_q;
  assign w_mult     = w_first ? cfg_mult  : mult_q;
  assign w_shift    = w_first ? cfg_shift : shift_q;
  assign w_acc_base = w_first ? '0 : acc_q;
  assign w_acc_sum  = w_acc_base + sum_in;

  always_comb begin
    tile_cnt_d = tile_cnt_q;
    acc_d      = acc_q;
    n_d        = n_q;
    bias_d     = bias_q;
    mult_d     = mult_q;
    shift_d    = shift_q;
    s1_d       = s1_q;
    s1_v_d     = 1'b0;
    s1_mult_d  = s1_mult_q;
    s1_shift_d = s1_shift_q;
    if (sum_valid) begin
      if (w_first) begin
        n_d     = cfg_num_tiles;
        bias_d  = cfg_bias;
        mult_d  = cfg_mult;
        shift_d = cfg_shift;
      end
      if (w_last) begin
        s1_d       = w_acc_sum + w_bias;
        s1_v_d     = 1'b1;
        s1_mult_d  = w_mult;   // mult/shift travel with the data
        s1_shift_d = w_shift;
        acc_d      = '0;
        tile_cnt_d = '0;
      end else begin
        acc_d      = w_acc_sum;
        tile_cnt_d = tile_cnt_q + TILE_W'(1);
      end
    end
  end

  // Signed multiply by the zero-extended unsigned multiplier
  logic signed [P_W-1:0] w_s1_x, w_m_x, w_prod;
  assign w_s1_x = P_W'($signed(s1_q));
  assign w_m_x  = P_W'({1'b0, s1_mult_q});
  assign w_prod = w_s1_x * w_m_x;

  // Round half toward +inf, arithmetic shift, then clamp
  logic signed [R_W-1:0] w_s2_x, w_rnd, w_r;
  logic [OUT_W-1:0]      w_sat;
  assign w_s2_x = R_W'($signed(s2_q));
  assign w_rnd  = (s2_shift_q == 6'd0) ? '0 : (R_W'(1) << (s2_shift_q - 6'd1));
  assign w_r    = (w_s2_x + w_rnd) >>> s2_shift_q;

  always_comb begin
    w_sat = w_r[OUT_W-1:0];
    if (w_r > C_HI)      w_sat = C_HI[OUT_W-1:0];
    else if (w_r < C_LO) w_sat = C_LO[OUT_W-1:0];
  end

  // Output buffer: a push while full is still accepted if the head pops
  logic w_pop, w_push, w_accept;
  assign w_pop    = (cnt_q != 2'd0) && q_ready;
  assign w_push   = s3_v_q;
  assign w_accept = w_push && ((cnt_q != 2'd2) || w_pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (w_push & ~w_accept);
    case ({w_pop, w_accept})
      2'b10: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) head_d = s3_q;
        else               tail_d = s3_q;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = s3_q;
        end else begin
          head_d = tail_q;
          tail_d = s3_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_cnt_q <= '0;
      acc_q      <= '0;
      n_q        <= '0;
      bias_q     <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      s1_q       <= '0;
      s1_v_q     <= 1'b0;
      s1_mult_q  <= '0;
      s1_shift_q <= '0;
      s2_q       <= '0;
      s2_v_q     <= 1'b0;
      s2_shift_q <= '0;
      s3_q       <= '0;
      s3_v_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tile_cnt_q <= tile_cnt_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      bias_q     <= bias_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      s1_q       <= s1_d;
      s1_v_q     <= s1_v_d;
      s1_mult_q  <= s1_mult_d;
      s1_shift_q <= s1_shift_d;
      s2_q       <= w_prod;
      s2_v_q     <= s1_v_q;
      s2_shift_q <= s1_shift_q;
      s3_q       <= w_sat;
      s3_v_q     <= s2_v_q;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q_out    = head_q;
  assign q_valid  = (cnt_q != 2'd0);
  assign overflow = ovf_q;
  assign busy     = (tile_cnt_q != '0) | s1_v_q | s2_v_q | s3_v_q | (cnt_q != 2'd0);

endmodule
`default_nettype wire
